// File: rtl/ahb_to_fpga_mem.sv
// ahb_to_fpga_mem: zero-wait AHB-Lite slave driving a one-cycle-latency byte-lane block RAM
// Writes are parked in a one-entry buffer and drained on the next cycle without a read.
module ahb_to_fpga_mem #(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-3:0] MEMADDR,
    output logic [31:0]   MEMWDATA,
    output logic [3:0]    MEMWREN,
    output logic          MEMCS,
    input  logic [31:0]   MEMRDATA
);
    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
    state_t state, state_nxt;
    logic accept, legal, rd_ap, wr_ap, flush, load, hit;
    logic wr_dphase, rd_dphase, buf_valid;
    logic [3:0] strb, wr_strb, buf_strb;
    logic [AW-3:0] wr_addr, rd_addr, buf_addr;
    logic [31:0] buf_data;

    assign accept = HRESETn & HSEL & HREADY & HTRANS[1];
    assign legal = (HSIZE == 3'd0) | (HSIZE == 3'd1 & ~HADDR[0]) | (HSIZE == 3'd2 & HADDR[1:0] == 2'b00);
    assign strb = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign rd_ap = accept & legal & ~HWRITE;
    assign wr_ap = accept & legal & HWRITE;
    // A read address phase owns the port; otherwise any buffered write drains
    assign flush = HRESETn & buf_valid & ~rd_ap;
    assign load = wr_dphase & HREADY;
    assign hit = buf_valid & (buf_addr == rd_addr);
    assign state_nxt = state == ERR1 ? ERR2 : (accept & ~legal) ? ERR1 : IDLE;

    assign MEMCS = rd_ap | flush;
    assign MEMADDR = rd_ap ? HADDR[AW-1:2] : buf_addr;
    assign MEMWREN = flush ? buf_strb : 4'b0000;
    assign MEMWDATA = buf_data;

    always_comb begin
        HRDATA = '0;
        for (int i = 0; i < 4; i++)
            HRDATA[8*i +: 8] = ~rd_dphase ? 8'h00 : (hit & buf_strb[i]) ? buf_data[8*i +: 8] : MEMRDATA[8*i +: 8];
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            wr_dphase <= 1'b0;
            rd_dphase <= 1'b0;
            buf_valid <= 1'b0;
            wr_addr   <= '0;
            wr_strb   <= '0;
            rd_addr   <= '0;
            buf_addr  <= '0;
            buf_strb  <= '0;
            buf_data  <= '0;
        end else begin
            state     <= state_nxt;
            HREADYOUT <= state_nxt != ERR1;
            HRESP     <= state_nxt != IDLE;
            if (HREADY) begin
                wr_dphase <= wr_ap;
                rd_dphase <= rd_ap;
            end
            if (wr_ap) begin
                wr_addr <= HADDR[AW-1:2];
                wr_strb <= strb;
            end
            if (rd_ap)
                rd_addr <= HADDR[AW-1:2];
            // A load on the same edge as a flush keeps the buffer full with the new write
            buf_valid <= load | (buf_valid & ~flush);
            if (load) begin
                buf_addr <= wr_addr;
                buf_strb <= wr_strb;
                buf_data <= HWDATA;
            end
        end
    end
endmodule

// File: tb/tb_ahb_to_fpga_mem.sv
// tb_ahb_to_fpga_mem: scoreboard bench with a block-RAM model behind the bridge
// Expected read data comes from a bench-side reference memory updated at each write data phase.
module tb_ahb_to_fpga_mem;
    logic        HCLK = 1'b0;
    logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, MEMCS;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA, HRDATA, MEMWDATA, MEMRDATA;
    logic [13:0] MEMADDR;
    logic [3:0]  MEMWREN;

    ahb_to_fpga_mem #(.AW(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .MEMADDR(MEMADDR),
        .MEMWDATA(MEMWDATA), .MEMWREN(MEMWREN), .MEMCS(MEMCS), .MEMRDATA(MEMRDATA)
    );

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    logic [31:0] mem [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] sb [$];
    int checks = 0, errors = 0, wren_cnt = 0;
    bit rd_dp = 1'b0;
    bit pw_valid = 1'b0;
    bit [13:0] pw_addr, last_maddr;
    bit [3:0] pw_strb, last_wren;
    bit [31:0] pw_data = '0;
    bit s_ready, s_resp, s_cs;
    bit [3:0] s_wren;
    bit [13:0] s_maddr;
    bit [31:0] s_rdata;

    localparam bit [1:0] NSEQ = 2'b10;

    function automatic bit legal_f(input bit [2:0] sz, input bit [15:0] a);
        return sz == 3'd0 || (sz == 3'd1 && !a[0]) || (sz == 3'd2 && a[1:0] == 2'b00);
    endfunction

    function automatic bit [3:0] strb_f(input bit [2:0] sz, input bit [15:0] a);
        if (sz == 3'd0) return 4'b0001 << a[1:0];
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Block RAM: one-cycle read latency, per-byte write enables
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 ^ i;
        mem[14'h0C0] = 32'h5566_7788;
        forever begin
            @(posedge HCLK);
            if (MEMCS === 1'b1) begin
                MEMRDATA <= mem[MEMADDR];
                for (int i = 0; i < 4; i++)
                    if (MEMWREN[i]) mem[MEMADDR][8*i +: 8] <= MEMWDATA[8*i +: 8];
            end
        end
    end

    always @(negedge HCLK) begin
        if (MEMWREN !== 4'b0000) begin
            wren_cnt++;
            last_maddr = MEMADDR;
            last_wren = MEMWREN;
        end
        if (rd_dp) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: read data 0x%08h with nothing expected", HRDATA);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (HRDATA !== exp) begin
                    errors++;
                    $display("FAIL hrdata: got 0x%08h expected 0x%08h", HRDATA, exp);
                end
            end
        end
    end

    task automatic drive(input bit sel, input bit [1:0] tr, input bit wr, input bit [2:0] sz,
                         input bit [15:0] a, input bit [31:0] wd);
        bit acc;
        HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = pw_data;
        @(negedge HCLK);
        acc = HRESETn && sel && (HREADY === 1'b1) && tr[1] && legal_f(sz, a);
        s_ready = HREADYOUT; s_resp = HRESP; s_cs = MEMCS; s_wren = MEMWREN;
        s_maddr = MEMADDR; s_rdata = HRDATA;
        @(posedge HCLK);
        #1;
        if (pw_valid)
            for (int i = 0; i < 4; i++)
                if (pw_strb[i]) ref_mem[pw_addr][8*i +: 8] = pw_data[8*i +: 8];
        pw_valid = acc && wr;
        if (pw_valid) begin
            pw_addr = a[15:2];
            pw_strb = strb_f(sz, a);
            pw_data = wd;
        end
        rd_dp = acc && !wr;
        if (rd_dp) sb.push_back(ref_mem[a[15:2]]);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 32'h0);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle();
        idle();
        HRESETn = 1'b1;
        idle();
        checks++;
        if ({s_ready, s_resp, s_cs, s_wren, s_rdata} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset: ready=%0b resp=%0b cs=%0b wren=%h rdata=%h, expected 1 0 0 0 0",
                     s_ready, s_resp, s_cs, s_wren, s_rdata);
        end
    endtask

    task automatic test_word_write_read();
        int c0 = wren_cnt;
        bit all_ready = 1'b1;
        drive(1'b1, NSEQ, 1'b1, 3'd2, 16'h0100, 32'hDEAD_BEEF); all_ready &= s_ready;
        idle(); all_ready &= s_ready;
        idle(); all_ready &= s_ready;
        drive(1'b1, NSEQ, 1'b0, 3'd2, 16'h0100, 32'h0); all_ready &= s_ready;
        idle(); all_ready &= s_ready;
        checks++;
        if (wren_cnt - c0 != 1 || last_maddr != 14'h040 || last_wren != 4'hF) begin
            errors++;
            $display("FAIL word_flush: pulses=%0d addr=%h wren=%h, expected 1 040 f", wren_cnt - c0, last_maddr, last_wren);
        end
        checks++;
        if (!all_ready) begin
            errors++;
            $display("FAIL word_ready: HREADYOUT dropped, expected constant 1");
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, NSEQ, 1'b1, 3'd2, 16'h0200, 32'h1122_3344);
        drive(1'b1, NSEQ, 1'b0, 3'd2, 16'h0200, 32'h0);
        checks++;
        if (s_cs !== 1'b1 || s_wren !== 4'h0 || s_maddr !== 14'h080) begin
            errors++;
            $display("FAIL b2b_read_port: cs=%0b wren=%h addr=%h, expected 1 0 080", s_cs, s_wren, s_maddr);
        end
        idle();
        checks++;
        if (s_wren !== 4'hF || s_maddr !== 14'h080) begin
            errors++;
            $display("FAIL b2b_flush: wren=%h addr=%h, expected f 080", s_wren, s_maddr);
        end
        idle();
    endtask

    task automatic test_byte_merge();
        drive(1'b1, NSEQ, 1'b1, 3'd0, 16'h0303, 32'hAB00_0000);
        drive(1'b1, NSEQ, 1'b0, 3'd2, 16'h0300, 32'h0);
        idle();
        checks++;
        if (s_wren !== 4'b1000) begin
            errors++;
            $display("FAIL byte_strobe: wren=%h expected 8", s_wren);
        end
        idle();
        checks++;
        if (mem[14'h0C0] !== 32'hAB66_7788) begin
            errors++;
            $display("FAIL byte_mem: mem=0x%08h expected 0xab667788", mem[14'h0C0]);
        end
    endtask

    task automatic test_error(input bit wr, input bit [2:0] sz, input bit [15:0] a);
        int c0 = wren_cnt;
        drive(1'b1, NSEQ, wr, sz, a, 32'h1234_5678);
        drive(1'b1, NSEQ, 1'b0, 3'd2, 16'h0100, 32'h0);
        checks++;
        if (s_ready !== 1'b0 || s_resp !== 1'b1 || s_cs !== 1'b0) begin
            errors++;
            $display("FAIL err1 @%h: ready=%0b resp=%0b cs=%0b, expected 0 1 0", a, s_ready, s_resp, s_cs);
        end
        idle();
        checks++;
        if (s_ready !== 1'b1 || s_resp !== 1'b1 || s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err2 @%h: ready=%0b resp=%0b rdata=%h, expected 1 1 0", a, s_ready, s_resp, s_rdata);
        end
        idle();
        checks++;
        if (s_ready !== 1'b1 || s_resp !== 1'b0 || wren_cnt != c0) begin
            errors++;
            $display("FAIL err_done @%h: ready=%0b resp=%0b pulses=%0d, expected 1 0 0", a, s_ready, s_resp, wren_cnt - c0);
        end
        drive(1'b1, NSEQ, 1'b0, 3'd2, {a[15:2], 2'b00}, 32'h0);
        idle();
    endtask

    task automatic test_read_hold();
        int c0 = wren_cnt;
        bit ok = 1'b1;
        drive(1'b1, NSEQ, 1'b1, 3'd2, 16'h0500, 32'h0BAD_F00D);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, NSEQ, 1'b0, 3'd2, 16'h0504, 32'h0);
            ok &= (s_wren == 4'h0) && (s_maddr == 14'h141);
        end
        checks++;
        if (!ok || wren_cnt != c0) begin
            errors++;
            $display("FAIL hold_no_flush: pulses=%0d during reads, expected 0", wren_cnt - c0);
        end
        drive(1'b1, NSEQ, 1'b1, 3'd2, 16'h0508, 32'hCAFE_0508);
        checks++;
        if (s_wren !== 4'hF || s_maddr !== 14'h140) begin
            errors++;
            $display("FAIL hold_flush: wren=%h addr=%h, expected f 140", s_wren, s_maddr);
        end
        idle();
        idle();
        checks++;
        if (mem[14'h140] !== 32'h0BAD_F00D || mem[14'h142] !== 32'hCAFE_0508) begin
            errors++;
            $display("FAIL hold_mem: 0x140=%h 0x142=%h, expected 0badf00d cafe0508", mem[14'h140], mem[14'h142]);
        end
    endtask

    task automatic test_reset_mid();
        int c0 = wren_cnt;
        logic [31:0] orig = ref_mem[14'h1C0];
        drive(1'b1, NSEQ, 1'b1, 3'd2, 16'h0700, 32'h7777_7777);
        idle();
        HRESETn = 1'b0;
        idle();
        checks++;
        if (s_wren !== 4'h0 || s_cs !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_port: wren=%h cs=%0b, expected 0 0", s_wren, s_cs);
        end
        HRESETn = 1'b1;
        ref_mem[14'h1C0] = orig;
        idle();
        checks++;
        if ({s_ready, s_resp, s_cs, s_wren, s_rdata} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0} || wren_cnt != c0) begin
            errors++;
            $display("FAIL rst_mid_state: ready=%0b resp=%0b cs=%0b wren=%h rdata=%h pulses=%0d, expected 1 0 0 0 0 0",
                     s_ready, s_resp, s_cs, s_wren, s_rdata, wren_cnt - c0);
        end
        drive(1'b1, NSEQ, 1'b0, 3'd2, 16'h0700, 32'h0);
        idle();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h5A00_0000 ^ i;
        ref_mem[14'h0C0] = 32'h5566_7788;
        test_reset();
        test_word_write_read();
        test_back_to_back();
        test_byte_merge();
        test_error(1'b1, 3'd1, 16'h0401);
        test_error(1'b0, 3'd2, 16'h0402);
        test_error(1'b0, 3'd3, 16'h0410);
        test_read_hold();
        test_reset_mid();
        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads never returned data, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within 100000 time units");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_to_fpga_mem.md
# ahb_to_fpga_mem

AHB-Lite slave bridge that acts as the initiator on the FPGA block-RAM/ROM memory interface (ADDR/WDATA/WREN/CS in, RDATA out, one-cycle read latency). It sits between the system bus matrix and a byte-lane block-RAM memory. It runs with zero wait states by holding each write in a one-entry write buffer. Read data is merged with any pending buffered bytes, and unaligned or oversized transfers are rejected with a two-cycle ERROR response.

## Interface
- AW, 16, byte-address width; the memory word address is AW-2 bits.
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  AW  byte address.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus ready (previous data phase ends).
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- MEMADDR  out  AW-2  memory word address (ADDR[AW-1:2]).
- MEMWDATA  out  32  memory write data.
- MEMWREN  out  4  per-byte write enables.
- MEMCS  out  1  memory access strobe.
- MEMRDATA  in  32  memory read data, valid one cycle after the address.

## Operation
- Accept: HSEL & HREADY & HTRANS[1].
- Byte strobes:
  - HSIZE=0: 1<<HADDR[1:0].
  - HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011.
  - HSIZE=2: 4'b1111.
- Illegal transfer (accepted, but HSIZE>2, or HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0):
  - no memory access, no buffer change.
  - response FSM goes IDLE->ERR1->ERR2->IDLE.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - Transfers presented during ERR1 are not accepted, because HREADY is low.
- Write:
  - Address phase: latch word address and strobes into the write data-phase registers; set wr_dphase.
  - End of the data phase: buf_addr, buf_strb and buf_data (from HWDATA) are loaded; buf_valid is set.
- Read address phase (legal): MEMCS=1, MEMADDR=HADDR[AW-1:2], MEMWREN=0; set rd_dphase and latch rd_addr.
- Flush: in any cycle with no legal read address phase and buf_valid=1:
  - MEMCS=1, MEMADDR=buf_addr, MEMWDATA=buf_data, MEMWREN=buf_strb.
  - buf_valid clears at that edge, unless a new buffer load happens on the same edge; the load wins.
- Port priority: a read address phase has priority over a flush.
- Buffer never overflows: every write address-phase cycle is a free port cycle, so the old entry is flushed before the new data is loaded.
- Read data phase: HRDATA byte i = (buf_valid & buf_addr==rd_addr & buf_strb[i]) ? buf_data byte i : MEMRDATA byte i.
  - The compare uses the buffer contents during the data-phase cycle.
  - This makes write-then-read of the same address return the new data.
- HRDATA=0 outside a read data phase.
- MEMWDATA=buf_data at all times; MEMWREN=0 whenever no flush is in progress.
- IDLE/BUSY or unselected transfers: no state change, OKAY response.

## Timing
- Legal transfers: zero wait states, HREADYOUT=1, HRESP=0.
- Read: MEMADDR is driven in the address-phase cycle; HRDATA is valid in the next cycle.
- Write reaches memory at the first free port cycle after its data phase, at the earliest the cycle after the data phase.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, MEMCS=0, MEMWREN=0, buf_valid=0, FSM=IDLE, wr_dphase=rd_dphase=0.
- Reset asserted mid-operation: a pending buffered write is discarded, and any ERROR response is abandoned.
- Write data phase coinciding with a read address phase: the read uses the memory port; the buffer loads at the end of the cycle.

## Test plan
- Word write 0x0000_0100 <= 0xDEADBEEF, then idle 2 cycles, then read 0x100 -> MEMWREN=4'hF seen once with MEMADDR=0x40; HRDATA=0xDEADBEEF; HREADYOUT stays 1.
- Back-to-back write 0x200 <= 0x11223344, then read 0x200 with no gap -> HRDATA=0x11223344 via buffer merge; the flush occurs in the cycle after the read address phase.
- Byte write 0x303 <= 0xAB (lane 3) over memory holding 0x55667788, then immediate read 0x300 -> HRDATA=0xAB667788; after the flush, memory holds 0xAB667788.
- Halfword write at 0x401 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no MEMWREN pulse and no buffer change. Same result for a word read at 0x402.
- Write 0x500 followed by continuous reads of 0x504 for 10 cycles -> no flush during the reads, buf_valid stays 1; the next write address phase flushes 0x500.
- HRESETn low for one cycle while buf_valid=1 -> buffer discarded (no MEMWREN), all outputs at reset values the following cycle.
